// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the skid pipeline stage: occupancy states,
// default multi-cycle occupancy and the wait-counter width helper.
package pipe_stage_skid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam int MC_CYCLES_DEFAULT = 4;

    // One extra bit beyond ceil(log2) keeps MC_CYCLES=1 at a legal 1-bit width.
    function automatic int wait_width(input int mc_cycles);
        return $clog2(mc_cycles) + 1;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_mc_wait_counter.sv
// Occupancy countdown for the head entry: loads on entry into main,
// decrements to zero and stops there.
module mc_wait_counter
    import pipe_stage_skid_pkg::*;
#(
    parameter int MC_CYCLES = MC_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic load,
    input  logic load_multi,
    output logic zero
);

    localparam int CW = wait_width(MC_CYCLES);
    localparam logic [CW-1:0] MULTI_LOAD = CW'(MC_CYCLES - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_multi ? MULTI_LOAD : '0;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - CW'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage with registered in_ready and an optional
// multi-cycle hold on the head entry before it is offered downstream.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int MC_CYCLES = MC_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_multi,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    state_t           state_reg;
    state_t           state_next;
    logic             in_ready_reg;
    logic [WIDTH-1:0] main_data_reg;
    logic [WIDTH-1:0] skid_data_reg;
    logic             skid_multi_reg;

    logic accept;
    logic consume;
    logic wait_zero;
    logic main_from_in;
    logic main_from_skid;
    logic skid_from_in;
    logic load_main;
    logic load_multi;

    assign accept    = in_valid && in_ready_reg;
    assign out_valid = (state_reg != ST_EMPTY) && wait_zero;
    assign consume   = out_valid && out_ready;

    always_comb begin
        state_next     = state_reg;
        main_from_in   = 1'b0;
        main_from_skid = 1'b0;
        skid_from_in   = 1'b0;
        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    state_next   = ST_ONE;
                    main_from_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    main_from_in = 1'b1;
                end else if (accept) begin
                    state_next   = ST_TWO;
                    skid_from_in = 1'b1;
                end else if (consume) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a consume can change state.
                if (consume) begin
                    state_next     = ST_ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_next     = ST_EMPTY;
            main_from_in   = 1'b0;
            main_from_skid = 1'b0;
            skid_from_in   = 1'b0;
        end
    end

    assign load_main  = main_from_in || main_from_skid;
    assign load_multi = main_from_skid ? skid_multi_reg : in_multi;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_EMPTY;
            in_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != ST_TWO);
        end
    end

    // Payload registers carry no reset; validity is tracked by state_reg.
    always_ff @(posedge clk) begin
        if (main_from_in) begin
            main_data_reg <= in_data;
        end else if (main_from_skid) begin
            main_data_reg <= skid_data_reg;
        end
        if (skid_from_in) begin
            skid_data_reg  <= in_data;
            skid_multi_reg <= in_multi;
        end
    end

    mc_wait_counter #(
        .MC_CYCLES(MC_CYCLES)
    ) u_wait (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .load      (load_main),
        .load_multi(load_multi),
        .zero      (wait_zero)
    );

    assign in_ready = in_ready_reg;
    assign out_data = main_data_reg;
    assign busy     = (state_reg != ST_EMPTY) || !wait_zero;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios with literal expectations,
// then random traffic compared every cycle against a queue-based model.
module tb_pipe_stage_skid;

    localparam int W  = 16;
    localparam int MC = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_multi;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;

    pipe_stage_skid #(.WIDTH(W), .MC_CYCLES(MC)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_multi (in_multi),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Model: FIFO of up to two entries; the head is offered from the cycle it
    // entered plus MC-1 extra cycles when it is a multi-cycle entry.
    typedef struct packed {
        logic [W-1:0] d;
        logic         m;
    } ent_t;

    ent_t q[$];
    int   cyc        = 0;
    int   head_ready = 0;
    logic m_in_ready = 1'b0;
    bit   live       = 1'b0;

    function automatic logic m_out_valid();
        return (q.size() > 0) && (cyc >= head_ready);
    endfunction

    always @(posedge clk) begin
        logic acc;
        logic con;
        logic new_head;
        ent_t e;
        con      = m_out_valid() && out_ready;
        acc      = in_valid && m_in_ready;
        new_head = 1'b0;
        cyc++;
        if (rst) begin
            q.delete();
            m_in_ready = 1'b0;
        end else if (flush) begin
            q.delete();
            m_in_ready = 1'b1;
        end else begin
            if (con) begin
                void'(q.pop_front());
                new_head = 1'b1;
            end
            if (acc) begin
                e.d = in_data;
                e.m = in_multi;
                if (q.size() == 0) new_head = 1'b1;
                q.push_back(e);
            end
            if (new_head && q.size() > 0)
                head_ready = cyc + (q[0].m ? MC - 1 : 0);
            m_in_ready = (q.size() < 2);
        end
        live = 1'b1;
    end

    always @(negedge clk) begin
        if (live) begin
            chk("cmp_out_valid", {31'b0, out_valid}, {31'b0, m_out_valid()});
            chk("cmp_in_ready", {31'b0, in_ready}, {31'b0, m_in_ready});
            chk("cmp_busy", {31'b0, busy}, {31'b0, q.size() > 0});
            if (m_out_valid())
                chk("cmp_out_data", {16'b0, out_data}, {16'b0, q[0].d});
        end
    end

    task automatic drive(input logic iv, input logic [W-1:0] d, input logic m,
                         input logic f, input logic ordy);
        in_valid  = iv;
        in_data   = d;
        in_multi  = m;
        flush     = f;
        out_ready = ordy;
    endtask

    task automatic out_chk(input string name, input logic ov, input logic [W-1:0] od,
                           input logic ir, input logic bz);
        chk({name, "_valid"}, {31'b0, out_valid}, {31'b0, ov});
        if (ov) chk({name, "_data"}, {16'b0, out_data}, {16'b0, od});
        chk({name, "_in_ready"}, {31'b0, in_ready}, {31'b0, ir});
        chk({name, "_busy"}, {31'b0, busy}, {31'b0, bz});
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        out_chk("reset", 1'b0, 16'h0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        out_chk("post_reset", 1'b0, 16'h0, 1'b1, 1'b0);

        // Back-to-back stream with downstream always ready.
        drive(1'b1, 16'h1111, 1'b0, 1'b0, 1'b1);
        @(negedge clk); out_chk("stream1", 1'b1, 16'h1111, 1'b1, 1'b1);
        drive(1'b1, 16'h2222, 1'b0, 1'b0, 1'b1);
        @(negedge clk); out_chk("stream2", 1'b1, 16'h2222, 1'b1, 1'b1);
        drive(1'b1, 16'h3333, 1'b0, 1'b0, 1'b1);
        @(negedge clk); out_chk("stream3", 1'b1, 16'h3333, 1'b1, 1'b1);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); out_chk("stream_end", 1'b0, 16'h0, 1'b1, 1'b0);

        // Backpressure fills the skid register.
        drive(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
        @(negedge clk); out_chk("bp_one", 1'b1, 16'hAAAA, 1'b1, 1'b1);
        drive(1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b0);
        @(negedge clk); out_chk("bp_two", 1'b1, 16'hAAAA, 1'b0, 1'b1);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); out_chk("bp_hold", 1'b1, 16'hAAAA, 1'b0, 1'b1);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); out_chk("bp_drain2", 1'b1, 16'hBBBB, 1'b1, 1'b1);
        @(negedge clk); out_chk("bp_empty", 1'b0, 16'h0, 1'b1, 1'b0);

        // Multi-cycle entry: offered MC cycles after acceptance.
        drive(1'b1, 16'h00C0, 1'b1, 1'b0, 1'b1);
        @(negedge clk); out_chk("mc_t1", 1'b0, 16'h0, 1'b1, 1'b1);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); out_chk("mc_t2", 1'b0, 16'h0, 1'b1, 1'b1);
        @(negedge clk); out_chk("mc_t3", 1'b0, 16'h0, 1'b1, 1'b1);
        @(negedge clk); out_chk("mc_t4", 1'b1, 16'h00C0, 1'b1, 1'b1);
        @(negedge clk); out_chk("mc_t5", 1'b0, 16'h0, 1'b1, 1'b0);

        // Flush in TWO with the head counter at 2.
        drive(1'b1, 16'h0D01, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 16'h0D02, 1'b0, 1'b0, 1'b0);
        @(negedge clk); out_chk("fl2_pre", 1'b0, 16'h0, 1'b0, 1'b1);
        drive(1'b1, 16'h0D03, 1'b0, 1'b1, 1'b0);
        @(negedge clk); out_chk("fl2_post", 1'b0, 16'h0, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        repeat (4) begin
            @(negedge clk); out_chk("fl2_gone", 1'b0, 16'h0, 1'b1, 1'b0);
        end

        // Flush in ONE while an entry is accepted: both discarded.
        drive(1'b1, 16'h0E01, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 16'h0E02, 1'b0, 1'b1, 1'b0);
        @(negedge clk); out_chk("fl1_post", 1'b0, 16'h0, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); out_chk("fl1_gone", 1'b0, 16'h0, 1'b1, 1'b0);

        // Reset during a multi-cycle countdown.
        drive(1'b1, 16'h0F01, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk); out_chk("rst_mid", 1'b0, 16'h0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk); out_chk("rst_after", 1'b0, 16'h0, 1'b1, 1'b0);
        drive(1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b1);
        @(negedge clk); out_chk("rst_new", 1'b1, 16'h5A5A, 1'b1, 1'b1);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);

        // Random traffic, checked every cycle by the compare process.
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 149) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
